// File: rtl/ee354_pkg.sv
// Shared state codes and default 100 MHz timing constants for the board-level
// button/switch conditioning blocks.
package ee354_pkg;

  typedef enum logic [2:0] {
    INI    = 3'd0,
    WQ     = 3'd1,
    SCEN_S = 3'd2,
    WH     = 3'd3,
    REPEAT = 3'd4,
    WFCR   = 3'd5
  } deb_state_e;

  localparam int DEB_25MS   = 2_500_000;
  localparam int HOLD_500MS = 50_000_000;
  localparam int MC_250MS   = 25_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs (buttons, switches).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_debouncer.sv
// Push-button conditioner: synchronise, debounce press/release, and derive
// single-clock, auto-repeat and continuous enables from a Moore FSM.
module btn_debouncer
  import ee354_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_25MS,
  parameter int HOLD_CYCLES = HOLD_500MS,
  parameter int MC_PERIOD   = MC_250MS,
  parameter int CNT_W       = 26
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       PB,
  output logic       DPB,
  output logic       SCEN,
  output logic       MCEN,
  output logic       CCEN,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MC_LAST   = CNT_W'(MC_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             pb_s;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  sync_2ff u_sync (
    .clk_i (board_clk),
    .rst_i (Reset),
    .d_i   (PB),
    .q_o   (pb_s)
  );

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= INI;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      INI: begin
        count_d = '0;
        if (pb_s) state_d = WQ;
      end
      WQ: begin
        // A release during qualification wins even on the terminal count.
        if (!pb_s) begin
          state_d = INI;
          count_d = '0;
        end else if (count_q == DEB_LAST) begin
          state_d = SCEN_S;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      SCEN_S: begin
        state_d = WH;
        count_d = '0;
      end
      WH: begin
        if (!pb_s) begin
          state_d = WFCR;
          count_d = '0;
        end else if (count_q == HOLD_LAST) begin
          state_d = REPEAT;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      REPEAT: begin
        if (!pb_s) begin
          state_d = WFCR;
          count_d = '0;
        end else begin
          count_d = (count_q == MC_LAST) ? '0 : count_q + CNT_ONE;
        end
      end
      WFCR: begin
        // Any bounce high restarts release qualification without a new SCEN.
        if (pb_s) begin
          count_d = '0;
        end else if (count_q == DEB_LAST) begin
          state_d = INI;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      default: begin
        state_d = INI;
        count_d = '0;
      end
    endcase
  end

  assign DPB     = (state_q == SCEN_S) || (state_q == WH) ||
                   (state_q == REPEAT) || (state_q == WFCR);
  assign SCEN    = (state_q == SCEN_S);
  assign MCEN    = (state_q == SCEN_S) || ((state_q == REPEAT) && (count_q == '0));
  assign CCEN    = (state_q == SCEN_S) || (state_q == REPEAT);
  assign state_o = state_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer: directed scenarios plus random button traces,
// compared cycle by cycle against a run-length reference model.
module tb_btn_debouncer;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int MC   = 4;

  logic       board_clk = 1'b0;
  logic       Reset;
  logic       PB;
  logic       DPB, SCEN, MCEN, CCEN;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int scen_cnt = 0;

  // Reference model: button phase plus run lengths of the synchronised input
  int   m_phase;   // 0 released, 1 press pulse, 2 held, 3 releasing
  int   m_hi_run;
  int   m_held;
  int   m_lo_run;
  logic m_s1, m_s2;

  btn_debouncer #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .MC_PERIOD   (MC),
    .CNT_W       (26)
  ) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .PB        (PB),
    .DPB       (DPB),
    .SCEN      (SCEN),
    .MCEN      (MCEN),
    .CCEN      (CCEN),
    .state_o   (state_o)
  );

  always #5 board_clk = ~board_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_hi_run = 0;
    m_held   = 0;
    m_lo_run = 0;
    m_s1     = 1'b0;
    m_s2     = 1'b0;
  endtask

  // One clock edge of the model: decide on the old synchronised value, then shift.
  task automatic model_edge(input logic pb_now);
    logic ps;
    ps = m_s2;
    case (m_phase)
      0: begin
        if (ps) begin
          m_hi_run++;
          if (m_hi_run == DEB + 1) m_phase = 1;
        end else begin
          m_hi_run = 0;
        end
      end
      1: begin
        m_phase = 2;
        m_held  = 0;
      end
      2: begin
        if (!ps) begin
          m_phase  = 3;
          m_lo_run = 0;
        end else begin
          m_held++;
        end
      end
      default: begin
        if (ps) m_lo_run = 0;
        else begin
          m_lo_run++;
          if (m_lo_run == DEB) begin
            m_phase  = 0;
            m_hi_run = 0;
          end
        end
      end
    endcase
    m_s2 = m_s1;
    m_s1 = pb_now;
  endtask

  task automatic check_outputs(input string tag);
    logic       e_rep, e_dpb, e_scen, e_mcen, e_ccen;
    logic [2:0] e_st;
    e_rep  = (m_phase == 2) && (m_held >= HOLD);
    e_dpb  = (m_phase != 0);
    e_scen = (m_phase == 1);
    e_mcen = e_scen || (e_rep && ((m_held - HOLD) % MC == 0));
    e_ccen = e_scen || e_rep;
    case (m_phase)
      0:       e_st = (m_hi_run == 0) ? 3'd0 : 3'd1;
      1:       e_st = 3'd2;
      2:       e_st = e_rep ? 3'd4 : 3'd3;
      default: e_st = 3'd5;
    endcase
    check_eq({tag, "_dpb"},   32'(DPB),     32'(e_dpb));
    check_eq({tag, "_scen"},  32'(SCEN),    32'(e_scen));
    check_eq({tag, "_mcen"},  32'(MCEN),    32'(e_mcen));
    check_eq({tag, "_ccen"},  32'(CCEN),    32'(e_ccen));
    check_eq({tag, "_state"}, 32'(state_o), 32'(e_st));
    if (SCEN === 1'b1) scen_cnt++;
  endtask

  task automatic step(input logic pb, input string tag);
    PB = pb;
    @(posedge board_clk);
    model_edge(pb);
    #1;
    check_outputs(tag);
  endtask

  task automatic run_level(input logic pb, input int n, input string tag);
    for (int i = 0; i < n; i++) step(pb, tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    Reset = 1'b1;
    #1;
    check_eq({tag, "_dpb"},   32'(DPB),     32'd0);
    check_eq({tag, "_scen"},  32'(SCEN),    32'd0);
    check_eq({tag, "_mcen"},  32'(MCEN),    32'd0);
    check_eq({tag, "_ccen"},  32'(CCEN),    32'd0);
    check_eq({tag, "_state"}, 32'(state_o), 32'd0);
    model_reset();
    repeat (2) @(posedge board_clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    PB    = 1'b0;
    model_reset();
    repeat (3) @(posedge board_clk);
    #1;
    check_eq("rst_dpb",   32'(DPB),     32'd0);
    check_eq("rst_scen",  32'(SCEN),    32'd0);
    check_eq("rst_mcen",  32'(MCEN),    32'd0);
    check_eq("rst_ccen",  32'(CCEN),    32'd0);
    check_eq("rst_state", 32'(state_o), 32'd0);
    Reset = 1'b0;
    run_level(1'b0, 4, "idle");

    // Clean press: exactly one SCEN
    scen_cnt = 0;
    run_level(1'b1, 12, "clean");
    run_level(1'b0, 20, "clean_rel");
    check_eq("clean_scen_count", 32'(scen_cnt), 32'd1);

    // Short glitch must never be accepted
    scen_cnt = 0;
    run_level(1'b1, 3, "glitch");
    run_level(1'b0, 20, "glitch_low");
    check_eq("glitch_scen_count", 32'(scen_cnt), 32'd0);

    // Press bounce then steady hold
    scen_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      run_level(1'b1, 2, "pbounce");
      run_level(1'b0, 2, "pbounce");
    end
    run_level(1'b1, 20, "pbounce_hold");
    run_level(1'b0, 20, "pbounce_rel");
    check_eq("pbounce_scen_count", 32'(scen_cnt), 32'd1);

    // Long hold into auto-repeat
    run_level(1'b1, 40, "repeat");
    run_level(1'b0, 20, "repeat_rel");

    // Release bounce after a hold: no second SCEN
    scen_cnt = 0;
    run_level(1'b1, 20, "rbounce_hold");
    run_level(1'b0, 2, "rbounce");
    run_level(1'b1, 1, "rbounce");
    run_level(1'b0, 20, "rbounce_low");
    check_eq("rbounce_scen_count", 32'(scen_cnt), 32'd1);

    // Reset while auto-repeating with the button held
    scen_cnt = 0;
    run_level(1'b1, 25, "rst_rep_hold");
    pulse_reset("rst_async");
    run_level(1'b1, 15, "rst_requal");
    run_level(1'b0, 20, "rst_rel");
    check_eq("reset_rescen_count", 32'(scen_cnt), 32'd2);

    // Random button traces
    for (int seg = 0; seg < 120; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 3) == 0)) ? int'($urandom_range(10, 30))
                                          : int'($urandom_range(1, 6));
      run_level(lvl, len, "rand");
    end
    run_level(1'b0, 20, "final");
    check_eq("final_state", 32'(state_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
